// File: rtl/clock_divider_core_pkg.sv
// Shared constants for the clock divider: game and VGA divider defaults,
// counter width and the shortened game terminal used by CLOCK_DIVIDER_SIM_FAST_EN.
package clock_divider_core_pkg;

    localparam int GAME_TERMINAL_DEFAULT = 833331;
    localparam int GAME_CNT_W            = 21;
    localparam int VGA_HALF_DEFAULT      = 2;
    localparam int SIM_FAST_TERMINAL     = 15;

endpackage

// File: rtl/clock_divider_core_toggle_divider.sv
// Next-state logic of a terminal-count counter with a toggle flop.
// The parent holds the state so both dividers share one implementation.
module toggle_divider
    import clock_divider_core_pkg::*;
#(
    parameter int W = 1
) (
    input  logic [W-1:0] cnt_q,
    input  logic         tog_q,
    input  logic [W-1:0] terminal,
    output logic [W-1:0] cnt_d,
    output logic         tog_d
);

    always_comb begin
        cnt_d = cnt_q + W'(1);
        tog_d = tog_q;
        if (cnt_q == terminal) begin
            cnt_d = '0;
            tog_d = ~tog_q;
        end else if (cnt_q > terminal) begin
            // Out-of-range count recovers to zero without producing an edge.
            cnt_d = '0;
        end
    end

endmodule

// File: rtl/clock_divider_core.sv
// Game tick and VGA pixel clock dividers from one system clock.
// Define CLOCK_DIVIDER_SIM_FAST_EN to shorten the game half-period to 16 cycles.
module clock_divider_core
    import clock_divider_core_pkg::*;
#(
    parameter int GAME_TERMINAL = GAME_TERMINAL_DEFAULT,
    parameter int VGA_HALF      = VGA_HALF_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    output logic game_tick,
    output logic vga_clk
);

`ifdef CLOCK_DIVIDER_SIM_FAST_EN
    localparam logic [GAME_CNT_W-1:0] GAME_TERM_EFF = GAME_CNT_W'(SIM_FAST_TERMINAL);
`else
    localparam logic [GAME_CNT_W-1:0] GAME_TERM_EFF = GAME_CNT_W'(GAME_TERMINAL);
`endif

    localparam int               VGA_W    = (VGA_HALF > 2) ? $clog2(VGA_HALF) : 1;
    localparam logic [VGA_W-1:0] VGA_TERM = VGA_W'(VGA_HALF - 1);

    // Game path state lives at this level so it is visible by name here.
    logic [GAME_CNT_W-1:0] game_tick_counter;
    logic [GAME_CNT_W-1:0] game_tick_counter_d;
    logic                  game_clk_in;
    logic                  game_clk_in_d;

    logic [VGA_W-1:0] vga_phase_q, vga_phase_d;
    logic             vga_tog_q, vga_tog_d;
    logic             vga_clk_q, vga_clk_d;

    toggle_divider #(.W(GAME_CNT_W)) u_game_div (
        .cnt_q    (game_tick_counter),
        .tog_q    (game_clk_in),
        .terminal (GAME_TERM_EFF),
        .cnt_d    (game_tick_counter_d),
        .tog_d    (game_clk_in_d)
    );

    toggle_divider #(.W(VGA_W)) u_vga_div (
        .cnt_q    (vga_phase_q),
        .tog_q    (vga_tog_q),
        .terminal (VGA_TERM),
        .cnt_d    (vga_phase_d),
        .tog_d    (vga_tog_d)
    );

    // Output flop delays the toggle by one edge, giving the 0,0,1,1 start.
    always_comb begin
        vga_clk_d = vga_tog_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            game_tick_counter <= '0;
            game_clk_in       <= 1'b0;
            vga_phase_q       <= '0;
            vga_tog_q         <= 1'b0;
            vga_clk_q         <= 1'b0;
        end else begin
            game_tick_counter <= game_tick_counter_d;
            game_clk_in       <= game_clk_in_d;
            vga_phase_q       <= vga_phase_d;
            vga_tog_q         <= vga_tog_d;
            vga_clk_q         <= vga_clk_d;
        end
    end

    assign game_tick = game_clk_in;
    assign vga_clk   = vga_clk_q;

endmodule

// File: tb/tb_clock_divider_core.sv
// Directed bench for clock_divider_core; also builds with CLOCK_DIVIDER_SIM_FAST_EN.
module tb_clock_divider_core;

`ifdef CLOCK_DIVIDER_SIM_FAST_EN
    localparam int TB_TERM = 15;
`else
    localparam int TB_TERM = 833331;
`endif

    logic clk;
    logic rst;
    logic game_tick;
    logic vga_clk;

    int errs;
    int checks;
    int n;
    int highs;

    logic exp_start [1:5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    clock_divider_core dut (
        .clk       (clk),
        .rst       (rst),
        .game_tick (game_tick),
        .vga_clk   (vga_clk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    initial begin
        errs   = 0;
        checks = 0;
        rst    = 1'b1;
        step(2);
        check("rst_cnt",  32'(dut.game_tick_counter), 0);
        check("rst_tick", 32'(game_tick), 0);
        check("rst_vga",  32'(vga_clk), 0);

        rst = 1'b0;
        step(1);
        n = 1;
        check("rel_tick", 32'(game_tick), 0);
        check("rel_vga",  32'(vga_clk), 0);
        check("rel_cnt",  32'(dut.game_tick_counter), 1);

        for (int e = 2; e <= 5; e++) begin
            step(1);
            n = e;
            check("vga_start", 32'(vga_clk), 32'(exp_start[e]));
        end

        highs = 0;
        for (int e = 6; e <= 13; e++) begin
            step(1);
            n = e;
            highs += int'(vga_clk);
            check("vga_steady", 32'(vga_clk), 32'(((e - 1) / 2) % 2));
        end
        check("vga_duty", 32'(highs), 4);

        step(500 - n);
        n = 500;
        check("mid_cnt",  32'(dut.game_tick_counter), 32'(n % (TB_TERM + 1)));
        check("mid_vga",  32'(vga_clk), 1);
        check("mid_tick", 32'(game_tick), 32'((n / (TB_TERM + 1)) % 2));

        rst = 1'b1;
        step(1);
        check("abort_cnt",  32'(dut.game_tick_counter), 0);
        check("abort_tick", 32'(game_tick), 0);
        check("abort_vga",  32'(vga_clk), 0);
        rst = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            step(1);
            n = e;
            check("restart_vga",  32'(vga_clk), 32'(exp_start[e]));
            check("restart_tick", 32'(game_tick), 0);
            check("restart_cnt",  32'(dut.game_tick_counter), 32'(e));
        end

`ifdef CLOCK_DIVIDER_SIM_FAST_EN
        step(15 - n);
        check("fast_cnt15",  32'(dut.game_tick_counter), 15);
        check("fast_tick15", 32'(game_tick), 0);
        step(1);
        check("fast_wrap",   32'(dut.game_tick_counter), 0);
        check("fast_rise",   32'(game_tick), 1);
        step(15);
        check("fast_tick31", 32'(game_tick), 1);
        step(1);
        check("fast_fall",   32'(game_tick), 0);
`else
        force dut.game_tick_counter = 21'd833331;
        force dut.game_clk_in = 1'b0;
        step(1);
        check("thr_held", 32'(game_tick), 0);
        release dut.game_clk_in;
        step(1);
        check("thr_toggle", 32'(game_tick), 1);
        release dut.game_tick_counter;

        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("thr_rst_tick", 32'(game_tick), 0);

        force dut.game_tick_counter = 21'd833325;
        #1;
        release dut.game_tick_counter;
        step(6);
        check("near_cnt",  32'(dut.game_tick_counter), 833331);
        check("near_tick", 32'(game_tick), 0);
        step(1);
        check("near_wrap", 32'(dut.game_tick_counter), 0);
        check("near_rise", 32'(game_tick), 1);

        force dut.game_tick_counter = 21'd2000000;
        #1;
        release dut.game_tick_counter;
        step(1);
        check("over_cnt",  32'(dut.game_tick_counter), 0);
        check("over_tick", 32'(game_tick), 1);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
